pipelined_compare_unit: RTL and testbench

//  Multi-mode, width-parametrised magnitude/equality comparator with a STAGES-deep

---
 rtl/pipelined_compare_unit_if.sv | 29 ++
 rtl/pipelined_compare_unit.sv | 122 ++++++++++++
 tb/tb_pipelined_compare_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pipelined_compare_unit_if.sv
// Handshake bundle for the pipelined comparator: operand/mode/tag request side
// and result/flags/tag response side, each with its own valid/ready pair.
interface pipelined_compare_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic [2:0]       mode;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic             result;
  logic [2:0]       flags;
  logic             mode_err;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, input_a, input_b, mode, tag_in, out_ready,
    input  in_ready, out_valid, result, flags, mode_err, tag_out
  );

  modport slave (
    input  in_valid, input_a, input_b, mode, tag_in, out_ready,
    output in_ready, out_valid, result, flags, mode_err, tag_out
  );
endinterface

// File: rtl/pipelined_compare_unit.sv
// Multi-mode comparator (EQ/NE/LT/GE/LTU/GEU) behind a STAGES-deep valid/ready
// pipeline; the tag rides along so branch resolution can match results to IDs.
module pipelined_compare_unit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input logic                    clock,
  input logic                    reset,
  pipelined_compare_unit_if.slave bus
);

  // payload carried past stage 0: {result, eq, lt_s, lt_u, mode_err, tag}
  localparam int PAY_W = 5 + TAG_W;

  localparam logic [2:0] MODE_EQ  = 3'd0;
  localparam logic [2:0] MODE_NE  = 3'd1;
  localparam logic [2:0] MODE_LT  = 3'd2;
  localparam logic [2:0] MODE_GE  = 3'd3;
  localparam logic [2:0] MODE_LTU = 3'd4;
  localparam logic [2:0] MODE_GEU = 3'd5;

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("pipelined_compare_unit: STAGES must be in 1..4");
    end
  endgenerate

  function automatic logic f_select(input logic [2:0] mode, input logic eq,
                                    input logic lt_s, input logic lt_u);
    logic res;
    case (mode)
      MODE_EQ:  res = eq;
      MODE_NE:  res = ~eq;
      MODE_LT:  res = lt_s;
      MODE_GE:  res = ~lt_s;
      MODE_LTU: res = lt_u;
      MODE_GEU: res = ~lt_u;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] w_adv;
  logic              w_in_ready;
  logic              w_accept;

  // A stage may advance if it, or any stage after it, is empty, or the consumer takes the head.
  always_comb begin
    logic w_run;
    w_run = bus.out_ready;
    w_adv = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_run    = w_run | ~r_vld[k];
      w_adv[k] = w_run;
    end
  end

  assign w_in_ready   = reset & w_adv[0];
  assign w_accept     = bus.in_valid & w_in_ready;
  assign bus.in_ready = w_in_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_vld <= '0;
    end else begin
      if (w_adv[0]) r_vld[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
        if (w_adv[k]) r_vld[k] <= r_vld[k-1];
      end
    end
  end

  // ---- stage 0: registered operands, compare evaluated from these ----
  logic [WIDTH-1:0] r_a_p0;
  logic [WIDTH-1:0] r_b_p0;
  logic [2:0]       r_mode_p0;
  logic [TAG_W-1:0] r_tag_p0;

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_a_p0    <= bus.input_a;
      r_b_p0    <= bus.input_b;
      r_mode_p0 <= bus.mode;
      r_tag_p0  <= bus.tag_in;
    end
  end

  // One extra bit makes both compares exact: sign-extend for signed, zero-extend for unsigned.
  logic signed [WIDTH:0] w_sa_p0, w_sb_p0, w_ua_p0, w_ub_p0;
  logic                  w_eq_p0, w_lt_s_p0, w_lt_u_p0, w_err_p0, w_res_p0;

  assign w_sa_p0   = {r_a_p0[WIDTH-1], r_a_p0};
  assign w_sb_p0   = {r_b_p0[WIDTH-1], r_b_p0};
  assign w_ua_p0   = {1'b0, r_a_p0};
  assign w_ub_p0   = {1'b0, r_b_p0};
  assign w_eq_p0   = (r_a_p0 == r_b_p0);
  assign w_lt_s_p0 = (w_sa_p0 < w_sb_p0);
  assign w_lt_u_p0 = (w_ua_p0 < w_ub_p0);
  assign w_err_p0  = r_mode_p0[2] & r_mode_p0[1];
  assign w_res_p0  = f_select(r_mode_p0, w_eq_p0, w_lt_s_p0, w_lt_u_p0);

  logic [PAY_W-1:0] w_pay [STAGES];

  assign w_pay[0] = {w_res_p0, w_eq_p0, w_lt_s_p0, w_lt_u_p0, w_err_p0, r_tag_p0};

  // ---- stages 1..STAGES-1: pure delay of the computed payload ----
  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    logic [PAY_W-1:0] r_pay_pk;
    always_ff @(posedge clock) begin
      if (w_adv[k] && r_vld[k-1]) r_pay_pk <= w_pay[k-1];
    end
    assign w_pay[k] = r_pay_pk;
  end

  // Outputs are masked by the head valid so reset and empty slots always read as zero.
  assign bus.out_valid = r_vld[STAGES-1];
  assign {bus.result, bus.flags, bus.mode_err, bus.tag_out} =
    r_vld[STAGES-1] ? w_pay[STAGES-1] : '0;

endmodule

// File: tb/tb_pipelined_compare_unit.sv
// Directed bench for pipelined_compare_unit (WIDTH=32, STAGES=2, TAG_W=4).
module tb_pipelined_compare_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  pipelined_compare_unit_if #(.WIDTH(32), .TAG_W(4)) bus ();

  pipelined_compare_unit #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // packed view {out_valid, result, flags, mode_err, tag_out}
  task automatic chk_out(input string name, input logic v, input logic r,
                         input logic [2:0] f, input logic e, input logic [3:0] t);
    chk(name, {22'd0, bus.out_valid, bus.result, bus.flags, bus.mode_err, bus.tag_out},
        {22'd0, v, r, f, e, t});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] t);
    bus.in_valid = v;
    bus.mode     = m;
    bus.input_a  = a;
    bus.input_b  = b;
    bus.tag_in   = t;
  endtask

  // Single op through an idle pipeline with out_ready=1: visible exactly 2 cycles after acceptance.
  task automatic run_op(input string name, input logic [2:0] m, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] t, input logic r,
                        input logic [2:0] f, input logic e);
    drive(1'b1, m, a, b, t);
    chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
    chk_out({name, "_lat1"}, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0);
    step();
    chk_out(name, 1'b1, r, f, e, t);
    step();
    chk_out({name, "_drained"}, 1'b0, 1'b0, 3'b000, 1'b0, 4'd0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);

    // reset state
    repeat (3) step();
    chk_out("reset_outputs", 1'b0, 1'b0, 3'b000, 1'b0, 4'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    reset = 1'b1;
    step();

    // basic modes
    run_op("ne_zero",   3'd1, 32'h0000_0000, 32'h0000_0000, 4'd3, 1'b0, 3'b100, 1'b0);
    run_op("lt_neg",    3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 4'd4, 1'b1, 3'b010, 1'b0);
    run_op("ltu_neg",   3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 4'd5, 1'b0, 3'b010, 1'b0);
    run_op("geu_neg",   3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 4'd6, 1'b1, 3'b010, 1'b0);
    run_op("ge_minmax", 3'd3, 32'h8000_0000, 32'h7FFF_FFFF, 4'd2, 1'b0, 3'b010, 1'b0);
    run_op("eq_diff",   3'd0, 32'd5,         32'd9,         4'd1, 1'b0, 3'b011, 1'b0);
    run_op("ltu_big",   3'd4, 32'h0000_0001, 32'hFFFF_FFFF, 4'd12, 1'b1, 3'b001, 1'b0);

    // illegal modes, then a legal op clears mode_err
    run_op("illegal7",  3'd7, 32'd5, 32'd9, 4'd7, 1'b0, 3'b011, 1'b1);
    run_op("eq_after",  3'd0, 32'd9, 32'd9, 4'd8, 1'b1, 3'b100, 1'b0);
    run_op("illegal6",  3'd6, 32'd1, 32'd0, 4'd9, 1'b0, 3'b000, 1'b1);

    // back-to-back: LTU i vs 8, tags 0..15
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (cyc >= 2) begin
        int i;
        logic lt, eq;
        i  = cyc - 2;
        lt = (i < 8);
        eq = (i == 8);
        chk_out($sformatf("b2b_out%0d", i), 1'b1, lt, {eq, lt, lt}, 1'b0, 4'(i));
      end else begin
        chk_out($sformatf("b2b_empty%0d", cyc), 1'b0, 1'b0, 3'b000, 1'b0, 4'd0);
      end
      chk($sformatf("b2b_in_ready%0d", cyc), {31'd0, bus.in_ready}, 32'd1);
      if (cyc < 16) drive(1'b1, 3'd4, 32'(cyc), 32'd8, 4'(cyc));
      else          drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
      step();
    end
    chk_out("b2b_done", 1'b0, 1'b0, 3'b000, 1'b0, 4'd0);

    // stall with a full pipeline
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd0, 32'd1, 32'd1, 4'd1);
    step();
    drive(1'b1, 3'd1, 32'd1, 32'd2, 4'd2);
    step();
    drive(1'b1, 3'd0, 32'd3, 32'd4, 4'd3);
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("stall_in_ready%0d", s), {31'd0, bus.in_ready}, 32'd0);
      chk_out($sformatf("stall_hold%0d", s), 1'b1, 1'b1, 3'b100, 1'b0, 4'd1);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
    chk_out("drain_tag2", 1'b1, 1'b1, 3'b011, 1'b0, 4'd2);
    step();
    chk_out("drain_tag3", 1'b1, 1'b0, 3'b011, 1'b0, 4'd3);
    step();
    chk_out("drain_empty", 1'b0, 1'b0, 3'b000, 1'b0, 4'd0);

    // reset with two entries in flight
    drive(1'b1, 3'd0, 32'd7, 32'd7, 4'd9);
    step();
    drive(1'b1, 3'd2, 32'd1, 32'd2, 4'd10);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 4'd0);
    chk_out("inflight_head", 1'b1, 1'b1, 3'b100, 1'b0, 4'd9);
    reset = 1'b0;
    step();
    chk_out("midreset_zero", 1'b0, 1'b0, 3'b000, 1'b0, 4'd0);
    chk("midreset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    reset = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      chk_out($sformatf("post_reset%0d", s), 1'b0, 1'b0, 3'b000, 1'b0, 4'd0);
    end
    run_op("after_reset", 3'd3, 32'd4, 32'd2, 4'd15, 1'b1, 3'b000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
